acc_sequencer: RTL and testbench
================================

Name: acc_sequencer

Overview:
Batch controller for the 8-bit accumulator datapath. It buffers up to DEPTH operands pushed from the switches. On start it clears the accumulator, then feeds one buffered operand per cycle. It captures the final sum with sticky overflow/carry flags and pulses done. It sits between the board I/O and the accumulator, replacing manual key-clocked stepping.

Parameters:
WIDTH, 8, operand/sum width
DEPTH, 4, operand buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
push  in  1  write push_data into buffer (IDLE only)
push_data  in  WIDTH  operand to buffer
full  out  1  buffer holds DEPTH entries
count  out  $clog2(DEPTH)+1  entries buffered
start  in  1  begin run (IDLE only)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse, result valid
result  out  WIDTH  captured final sum
ovf_flag  out  1  sticky: any step in run signalled overflow
carry_flag  out  1  sticky: any step in run signalled carry
acc_clr  out  1  accumulator synchronous clear
acc_en  out  1  accumulator add-enable
acc_operand  out  WIDTH  operand for current step (buffer head)
acc_sum  in  WIDTH  accumulator sum
acc_overflow  in  1  signed overflow of last add
acc_carry  in  1  carry-out of last add

Behaviour:
- Accumulator contract: acc_clr sets sum=0 and flags=0 at the edge. acc_en adds acc_operand at the edge. acc_sum and flags reflect the step on the cycle after acc_en.
- Reset (rst=0, async): state IDLE; buffer empty; count=0, full=0, busy=0, done=0, result=0, ovf_flag=0, carry_flag=0, acc_clr=0, acc_en=0, acc_operand=0.
- Reset mid-run aborts immediately. Buffered operands are discarded.
- Buffer:
  - FIFO with wrap-around pointers.
  - push accepted only in IDLE with !full and !start. Otherwise it is silently dropped, including push while full, while busy, or in the same cycle as start.
- FSM states: IDLE, CLEAR, FEED, WAIT, DONE.
  - IDLE: start with count>0 -> CLEAR. start with count==0 is ignored.
  - CLEAR: acc_clr=1 for one cycle; ovf_flag and carry_flag cleared -> FEED.
  - FEED:
    - acc_en=1, acc_operand=head, pop one entry per cycle.
    - On the cycle the last entry pops -> WAIT.
  - WAIT: capture result<=acc_sum -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Sticky flags:
  - ovf_flag |= acc_overflow and carry_flag |= acc_carry in every cycle that follows an acc_en cycle (FEED after the first step, and WAIT).
  - Flags hold after DONE until the next CLEAR.
- Latency: start sampled at cycle t with N operands gives:
  - CLEAR at t+1
  - acc_en at t+2..t+N+1
  - WAIT at t+N+2
  - done at t+N+3
- start while busy is ignored. result is unchanged outside WAIT.
- Arithmetic is performed by the accumulator. The sequencer never modifies the sum; it wraps modulo 2^WIDTH.

Optional Feature:
ACC_SEQ_HALT_ON_OVF_EN
- Defined:
  - In FEED, if acc_overflow=1 (reflecting the previous step), acc_en is held 0 that cycle.
  - All remaining buffer entries are flushed (count=0) and the FSM goes to WAIT.
  - result is the overflowing sum; ovf_flag=1.
- Undefined: overflow only sets the sticky flag; all operands are always fed.

Decomposition:
- Package acc_seq_pkg:
  - FSM state enum
  - default WIDTH/DEPTH constants
  - count-width constant
- Natural sub-module: acc_seq_fifo.
  - Synchronous FIFO with push/pop, head, count and full.
  - Pointer wrap and count logic live there.
  - The FSM stays in acc_sequencer.

Test Plan:
1. Push 3,5,7; start -> acc_clr at t+1; acc_en with operands 3,5,7 at t+2..t+4; done at t+6; result=15, ovf_flag=0, carry_flag=0, count=0.
2. Push 100,100; start -> result=0xC8, ovf_flag=1, carry_flag=0, done at t+5.
3. Push 0xFF,0x01; start -> result=0x00, carry_flag=1, ovf_flag=0.
4. Push 5 values -> full=1 after the 4th, 5th dropped, count=4. After draining, start with count=0 -> busy stays 0, no done. Push+start in the same cycle -> push dropped.
5. Push 1,2,3; start; deassert rst at t+3 (mid-FEED) -> all outputs 0, count=0, IDLE. The next run behaves as in case 1.
6. Push 100,100,1,1:
   - With ACC_SEQ_HALT_ON_OVF_EN: two acc_en pulses, result=0xC8, ovf_flag=1, count=0, done at t+6.
   - Without: four pulses, result=0xCA, ovf_flag=1, done at t+7.

Source files
------------

// File: rtl/acc_seq_pkg.sv
// Shared definitions for the accumulator batch sequencer: FSM state
// encoding, default geometry and the buffer count width.
package acc_seq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Count must reach DEPTH itself, hence one bit more than the pointer width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/acc_seq_if.sv
// Bus between the sequencer (master) and the 8-bit accumulator (slave).
interface acc_seq_if import acc_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);

  logic             acc_clr;
  logic             acc_en;
  logic [WIDTH-1:0] acc_operand;
  logic [WIDTH-1:0] acc_sum;
  logic             acc_overflow;
  logic             acc_carry;

  modport master (
    output acc_clr, acc_en, acc_operand,
    input  acc_sum, acc_overflow, acc_carry
  );

  modport slave (
    input  acc_clr, acc_en, acc_operand,
    output acc_sum, acc_overflow, acc_carry
  );

endinterface

// File: rtl/acc_seq_fifo.sv
// Operand buffer: small synchronous FIFO with wrap-around pointers, a
// flush that discards everything, and an occupancy count.
module acc_seq_fifo import acc_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and count update; a flush wins over any push or pop that cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CntW'(1);
    end
  end

  // Pointer and count registers, cleared by reset so the buffer starts empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/acc_sequencer.sv
// Batch controller for the accumulator: buffers operands while idle, then on
// start clears the accumulator, feeds one operand per cycle, captures the sum
// with sticky overflow/carry flags and pulses done.
// Optional macro ACC_SEQ_HALT_ON_OVF_EN: stop feeding and flush the buffer as
// soon as a step reports signed overflow.
module acc_sequencer import acc_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  output logic                        full,
  output logic [cnt_width(DEPTH)-1:0] count,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH-1:0]            result,
  output logic                        ovf_flag,
  output logic                        carry_flag,
  acc_seq_if.master                   acc
);

  localparam int CntW = cnt_width(DEPTH);

`ifdef ACC_SEQ_HALT_ON_OVF_EN
  localparam bit HaltOnOvf = 1'b1;
`else
  localparam bit HaltOnOvf = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fifo_head;
  logic             push_req;
  logic             pop;
  logic             flush;
  logic             halt;
  logic             clr_d, en_d;
  logic [WIDTH-1:0] operand_d;
  logic             en_prev_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q, carry_q;

  assign push_req = push && (state_q == IDLE) && !start;
  assign halt     = HaltOnOvf && (state_q == FEED) && en_prev_q && acc.acc_overflow;

  acc_seq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_req),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (fifo_head),
    .count_o     (count),
    .full_o      (full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: leave FEED on the last pop, or early on a halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (count != '0)) state_d = CLEAR;
      CLEAR:   state_d = FEED;
      FEED:    if (halt || (count == CntW'(1))) state_d = WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; operand is forced to zero outside FEED.
  always_comb begin
    clr_d     = 1'b0;
    en_d      = 1'b0;
    operand_d = '0;
    pop       = 1'b0;
    flush     = 1'b0;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    case (state_q)
      CLEAR: clr_d = 1'b1;
      FEED: begin
        operand_d = fifo_head;
        if (halt) begin
          flush = 1'b1;
        end else begin
          en_d = 1'b1;
          pop  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Result capture and sticky flags, sampled on the cycle after each add.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_prev_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      en_prev_q <= en_d;
      if (state_q == CLEAR) begin
        ovf_q   <= 1'b0;
        carry_q <= 1'b0;
      end else if (en_prev_q) begin
        ovf_q   <= ovf_q | acc.acc_overflow;
        carry_q <= carry_q | acc.acc_carry;
      end
      if (state_q == WAIT) result_q <= acc.acc_sum;
    end
  end

  assign acc.acc_clr     = clr_d;
  assign acc.acc_en      = en_d;
  assign acc.acc_operand = operand_d;
  assign result          = result_q;
  assign ovf_flag        = ovf_q;
  assign carry_flag      = carry_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Bench for acc_sequencer: behavioural accumulator on the bus, directed
// cases followed by randomized batches checked against a queue-based model.
module tb_acc_sequencer;
  import acc_seq_pkg::*;

  localparam int WIDTH = DEF_WIDTH;
  localparam int DEPTH = DEF_DEPTH;
  localparam int CW    = DEF_CNT_W;
`ifdef ACC_SEQ_HALT_ON_OVF_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             push = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             full, busy, done, ovf_flag, carry_flag;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result;

  acc_seq_if #(.WIDTH(WIDTH)) acc ();

  acc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .full       (full),
    .count      (count),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .ovf_flag   (ovf_flag),
    .carry_flag (carry_flag),
    .acc        (acc)
  );

  always #5 clk = ~clk;

  // Behavioural accumulator: clear or add at the edge, flags of the last add.
  logic [7:0] accSum   = 8'h00;
  logic       accOvf   = 1'b0;
  logic       accCarry = 1'b0;
  assign acc.acc_sum      = accSum;
  assign acc.acc_overflow = accOvf;
  assign acc.acc_carry    = accCarry;

  always @(posedge clk) begin
    logic [8:0] t;
    t = {1'b0, accSum} + {1'b0, acc.acc_operand};
    if (acc.acc_clr) begin
      accSum   <= 8'h00;
      accOvf   <= 1'b0;
      accCarry <= 1'b0;
    end else if (acc.acc_en) begin
      accSum   <= t[7:0];
      accCarry <= t[8];
      accOvf   <= (accSum[7] == acc.acc_operand[7]) && (t[7] != accSum[7]);
    end
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] modelQ[$];
  logic [7:0] expFed[$];
  logic [7:0] fed[$];
  logic [7:0] expSum;
  bit         expOvf, expCarry;
  int         expDone;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int toSigned(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Reference: integer arithmetic over the buffered operands.
  task automatic predictRun();
    int  sumU, u, s;
    bit  halted;
    sumU = 0; halted = 0; expOvf = 0; expCarry = 0;
    expFed.delete();
    for (int i = 0; i < modelQ.size() && !halted; i++) begin
      u = sumU + int'(modelQ[i]);
      s = toSigned(sumU) + toSigned(int'(modelQ[i]));
      if (u > 255) expCarry = 1;
      if (s > 127 || s < -128) begin
        expOvf = 1;
        if (HALT && i != modelQ.size() - 1) halted = 1;
      end
      sumU = u % 256;
      expFed.push_back(modelQ[i]);
    end
    expSum  = sumU[7:0];
    expDone = halted ? expFed.size() + 4 : expFed.size() + 3;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " count"}, count, 0);
    checkOutput({tag, " full"}, full, 0);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " done"}, done, 0);
    checkOutput({tag, " result"}, result, 0);
    checkOutput({tag, " ovf"}, ovf_flag, 0);
    checkOutput({tag, " carry"}, carry_flag, 0);
    checkOutput({tag, " acc_clr"}, acc.acc_clr, 0);
    checkOutput({tag, " acc_en"}, acc.acc_en, 0);
    checkOutput({tag, " acc_operand"}, acc.acc_operand, 0);
  endtask

  // Push one operand while idle (called at a falling edge).
  task automatic applyStimulus(input logic [7:0] v);
    push = 1'b1; push_data = v;
    @(posedge clk); @(negedge clk);
    push = 1'b0;
    if (modelQ.size() < DEPTH) modelQ.push_back(v);
    checkOutput("push count", count, modelQ.size());
    checkOutput("push full", full, modelQ.size() == DEPTH);
  endtask

  // Start a run and observe it cycle by cycle; optional push on the start
  // cycle and random push/start noise while busy must both be ignored.
  task automatic runBatch(input string tag, input bit pushToo, input bit noise);
    int clrCycle, clrPulses, enFirst, doneCycle, n;
    logic [7:0] gotResult;
    logic gotOvf, gotCarry;
    predictRun();
    fed.delete();
    clrCycle = -1; clrPulses = 0; enFirst = -1; doneCycle = -1;
    gotResult = 8'h00; gotOvf = 0; gotCarry = 0;
    start = 1'b1;
    if (pushToo) begin push = 1'b1; push_data = 8'($urandom); end
    @(posedge clk); @(negedge clk);
    start = 1'b0; push = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (acc.acc_clr) begin clrPulses++; if (clrCycle < 0) clrCycle = c; end
      if (acc.acc_en) begin fed.push_back(acc.acc_operand); if (enFirst < 0) enFirst = c; end
      if (done) begin
        doneCycle = c; gotResult = result; gotOvf = ovf_flag; gotCarry = carry_flag;
        break;
      end
      if (noise) begin
        push = 1'($urandom_range(0, 1)); push_data = 8'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      @(posedge clk); @(negedge clk);
    end
    push = 1'b0; start = 1'b0;
    modelQ.delete();
    checkOutput({tag, " clr cycle"}, clrCycle, 1);
    checkOutput({tag, " clr pulses"}, clrPulses, 1);
    checkOutput({tag, " first acc_en"}, enFirst, 2);
    checkOutput({tag, " acc_en pulses"}, fed.size(), expFed.size());
    n = (fed.size() < expFed.size()) ? fed.size() : expFed.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s operand %0d", tag, i), fed[i], expFed[i]);
    checkOutput({tag, " done cycle"}, doneCycle, expDone);
    checkOutput({tag, " result"}, gotResult, expSum);
    checkOutput({tag, " ovf_flag"}, gotOvf, expOvf);
    checkOutput({tag, " carry_flag"}, gotCarry, expCarry);
    checkOutput({tag, " count after"}, count, 0);
    @(posedge clk); @(negedge clk);
    checkOutput({tag, " busy after"}, busy, 0);
    checkOutput({tag, " done width"}, done, 0);
    checkOutput({tag, " result held"}, result, expSum);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkReset("reset");
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(8'd3); applyStimulus(8'd5); applyStimulus(8'd7);
    runBatch("small sum", 0, 0);

    applyStimulus(8'd100); applyStimulus(8'd100);
    runBatch("signed ovf", 0, 0);

    applyStimulus(8'hFF); applyStimulus(8'h01);
    runBatch("carry out", 0, 0);

    for (int i = 1; i <= 5; i++) applyStimulus(8'(i * 10));
    runBatch("full drain", 0, 1);

    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("empty start busy", busy, 0);
      checkOutput("empty start done", done, 0);
      @(posedge clk); @(negedge clk);
    end

    push = 1'b1; push_data = 8'd42; start = 1'b1;
    @(posedge clk); @(negedge clk);
    push = 1'b0; start = 1'b0;
    checkOutput("push+start count", count, 0);
    checkOutput("push+start busy", busy, 0);

    applyStimulus(8'd9);
    runBatch("push on start", 1, 0);

    applyStimulus(8'd1); applyStimulus(8'd2); applyStimulus(8'd3);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 checkReset("mid-run reset");
    modelQ.delete();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    applyStimulus(8'd3); applyStimulus(8'd5); applyStimulus(8'd7);
    runBatch("after reset", 0, 0);

    applyStimulus(8'd100); applyStimulus(8'd100); applyStimulus(8'd1); applyStimulus(8'd1);
    runBatch("ovf mid-batch", 0, 0);

    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, DEPTH + 1);
      for (int k = 0; k < n; k++)
        applyStimulus(($urandom_range(0, 3) == 0) ? 8'h7F + 8'($urandom_range(0, 1)) : 8'($urandom));
      runBatch($sformatf("random %0d", r), 1'($urandom_range(0, 1)), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
